rca_lsq_responder: RTL

Responder end of the RCA operating-unit load/store interface. It accepts requests from one OU (new_request/addr/data/fn3/load/store) into an in-order queue and issues them one at a time to a simple word-wide memory port. For loads it aligns and sign- or zero-extends the returned data and presents it on load_data with a load_complete pulse. It sits between the OU grid and the data-memory arbiter.

---
 rtl/rca_config.sv | 60 ++++++
 rtl/taiga_config.sv | 6 +
 rtl/rca_lsq_fifo.sv | 59 +++++
 rtl/rca_lsq_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rca_config.sv
// RCA load/store types: request record, funct3 encodings, responder states,
// and the byte-lane / load-extension helpers used by the responder.
package rca_config;

  import taiga_config::*;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            is_load;
  } lsq_req_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    LSQ_IDLE = 2'd0,
    LSQ_REQ  = 2'd1,
    LSQ_WAIT = 2'd2
  } lsq_state_t;

  // Byte enables for a store; unknown widths produce an empty mask.
  function automatic logic [3:0] lsq_be(lsq_req_t r);
    case (r.fn3)
      LS_B:    return 4'b0001 << r.addr[1:0];
      LS_H:    return r.addr[1] ? 4'b1100 : 4'b0011;
      LS_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane so the enables pick the target.
  function automatic logic [XLEN-1:0] lsq_wdata(lsq_req_t r);
    case (r.fn3)
      LS_B:    return {4{r.data[7:0]}};
      LS_H:    return {2{r.data[15:0]}};
      default: return r.data;
    endcase
  endfunction

  // Move the addressed lane down to bit 0 and extend it to a full word.
  function automatic logic [XLEN-1:0] lsq_extend(input logic [XLEN-1:0] rdata,
                                                 input logic [1:0] lane,
                                                 input logic [2:0] fn3);
    logic [XLEN-1:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (fn3)
      LS_B:    return {{24{sh[7]}}, sh[7:0]};
      LS_BU:   return {24'h0, sh[7:0]};
      LS_H:    return {{16{sh[15]}}, sh[15:0]};
      LS_HU:   return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/taiga_config.sv
// Core-wide configuration shared with the rest of the processor.
package taiga_config;

  localparam int XLEN = 32;

endpackage

// File: rtl/rca_lsq_fifo.sv
// In-order request queue: wrap-around read/write pointers plus an occupancy
// count. Exposes the head entry and the entry behind it.
module rca_lsq_fifo
  import rca_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  lsq_req_t               i_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output lsq_req_t               o_head,
  output lsq_req_t               o_next,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  lsq_req_t      r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + PW'(1)];
  assign o_count = r_count;

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rca_lsq_responder.sv
// Load/store responder for one RCA operating unit. Queues OU requests and
// issues them one at a time on a word-wide memory port; loads are aligned
// and extended before being returned with a one-cycle load_complete.
// Optional: RCA_LSQ_LOAD_TIMEOUT_EN adds a wait counter that completes a load
// with zero data when memory never answers, flagged on sticky load_timeout.
// Memory handshake: a transfer happens on a cycle with mem_req && mem_ack;
// mem_req and every mem_* field stay stable until then. Read data returns
// later on mem_rvalid, with at most one load outstanding.
module rca_lsq_responder
  import taiga_config::*;
  import rca_config::*;
#(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_request,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_rnw,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
`ifdef RCA_LSQ_LOAD_TIMEOUT_EN
  output logic            load_timeout,
`endif
  output lsq_state_t      dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  lsq_state_t      r_state, w_state_nx;
  logic            r_mem_req, w_mem_req_nx;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_nx;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nx;
  logic [3:0]      r_mem_be, w_mem_be_nx;
  logic            r_mem_rnw, w_mem_rnw_nx;
  logic [XLEN-1:0] r_load_data, w_ld_val;
  logic            r_load_complete, w_ld_done;
  logic            w_push, w_pop, w_full, w_empty, w_issue;
  lsq_req_t        w_req_in, w_head, w_next, w_src;
  logic [CW-1:0]   w_count;

`ifdef RCA_LSQ_LOAD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_load_timeout;
  logic                 w_timeout_hit;
`else
  logic w_unused_timeout_w;
  assign w_unused_timeout_w = ^TIMEOUT_W;
`endif

  assign w_req_in = '{addr: addr, data: data, fn3: fn3, is_load: load};
  // Requests that are both or neither load/store are silently discarded.
  assign w_push   = new_request && !w_full && (load ^ store);

  rca_lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_req_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count)
  );

  // Next-state, pop/complete decisions and the next registered mem_* fields.
  always_comb begin
    w_state_nx     = r_state;
    w_mem_req_nx   = r_mem_req;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_mem_be_nx    = r_mem_be;
    w_mem_rnw_nx   = r_mem_rnw;
    w_issue        = 1'b0;
    w_src          = w_head;
    w_pop          = 1'b0;
    w_ld_done      = 1'b0;
    w_ld_val       = '0;
`ifdef RCA_LSQ_LOAD_TIMEOUT_EN
    w_timeout_hit  = 1'b0;
`endif
    case (r_state)
      LSQ_IDLE: begin
        if (!w_empty) begin
          w_state_nx   = LSQ_REQ;
          w_mem_req_nx = 1'b1;
          w_issue      = 1'b1;
        end
      end
      LSQ_REQ: begin
        if (mem_ack) begin
          if (w_head.is_load) begin
            w_state_nx   = LSQ_WAIT;
            w_mem_req_nx = 1'b0;
          end else begin
            w_pop = 1'b1;
            // Only an entry already resident can be chained straight on.
            if (w_count > CW'(1)) begin
              w_issue = 1'b1;
              w_src   = w_next;
            end else begin
              w_state_nx   = LSQ_IDLE;
              w_mem_req_nx = 1'b0;
            end
          end
        end
      end
      LSQ_WAIT: begin
        if (mem_rvalid) begin
          w_pop      = 1'b1;
          w_ld_done  = 1'b1;
          w_ld_val   = lsq_extend(mem_rdata, w_head.addr[1:0], w_head.fn3);
          w_state_nx = LSQ_IDLE;
        end
`ifdef RCA_LSQ_LOAD_TIMEOUT_EN
        else if (&r_wait_cnt) begin
          w_pop         = 1'b1;
          w_ld_done     = 1'b1;
          w_ld_val      = '0;
          w_timeout_hit = 1'b1;
          w_state_nx    = LSQ_IDLE;
        end
`endif
      end
      default: w_state_nx = LSQ_IDLE;
    endcase
    if (w_issue) begin
      w_mem_addr_nx  = {w_src.addr[XLEN-1:2], 2'b00};
      w_mem_wdata_nx = lsq_wdata(w_src);
      w_mem_be_nx    = w_src.is_load ? 4'b1111 : lsq_be(w_src);
      w_mem_rnw_nx   = w_src.is_load;
    end
  end

  // State and registered memory-port / load-result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= LSQ_IDLE;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_be        <= '0;
      r_mem_rnw       <= 1'b0;
      r_load_data     <= '0;
      r_load_complete <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_mem_req       <= w_mem_req_nx;
      r_mem_addr      <= w_mem_addr_nx;
      r_mem_wdata     <= w_mem_wdata_nx;
      r_mem_be        <= w_mem_be_nx;
      r_mem_rnw       <= w_mem_rnw_nx;
      r_load_complete <= w_ld_done;
      if (w_ld_done) r_load_data <= w_ld_val;
    end
  end

`ifdef RCA_LSQ_LOAD_TIMEOUT_EN
  // Wait-cycle counter restarts on every entry to WAIT; timeout flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt     <= '0;
      r_load_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == LSQ_WAIT) ? r_wait_cnt + TIMEOUT_W'(1) : '0;
      if (w_timeout_hit) r_load_timeout <= 1'b1;
    end
  end
  assign load_timeout = r_load_timeout;
`endif

  assign lsq_full      = w_full;
  assign load_data     = r_load_data;
  assign load_complete = r_load_complete;
  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_be        = r_mem_be;
  assign mem_rnw       = r_mem_rnw;
  assign dbg_state     = r_state;

endmodule
